// File: rtl/etapa_fetch_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM encoding, the NOP word, the branch
// opcodes used by the ID comparator, and the IF/ID register layout.
package etapa_fetch_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Instruction addresses are always word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic is_branch_op(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/etapa_fetch_reg_if_id.sv
// IF/ID pipeline register: flush inserts a bubble, load captures the fetched
// instruction, otherwise it holds. Flush wins over load.
module reg_if_id
  import etapa_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = etapa_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] fetched_instr,
  input  logic [31:0] fetched_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  if_id_t q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else if (flush) begin
      q <= '{instr: NOP_INSTR, pc_plus4: fetched_pc_plus4, valid: 1'b0};
    end else if (load) begin
      q <= '{instr: fetched_instr, pc_plus4: fetched_pc_plus4, valid: 1'b1};
    end
  end

  assign instr    = q.instr;
  assign pc_plus4 = q.pc_plus4;
  assign valid    = q.valid;

endmodule

// File: rtl/etapa_fetch.sv
// MIPS instruction-fetch stage: PC, boot/run FSM, IF/ID register and branch redirect.
// Optional taken/stall counters are built when BRANCH_STATS_EN is defined.
module etapa_fetch
  import etapa_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = etapa_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        salto,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id,
  output logic [31:0] cnt_taken,
  output logic [31:0] cnt_stall
);

  localparam logic [31:0] PC_RESET = word_align(RESET_PC);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic        ifid_load, ifid_flush;
  logic        taken_evt, stall_evt;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= PC_RESET;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    taken_evt  = 1'b0;
    stall_evt  = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt  = ST_RUN;
        ifid_flush = 1'b1;
      end
      ST_RUN: begin
        // ID operands are meaningless during a stall, so salto is ignored then.
        if (stall) begin
          stall_evt = 1'b1;
        end else if (salto) begin
          taken_evt  = 1'b1;
          ifid_flush = 1'b1;
          pc_nxt     = word_align(branch_target);
        end else begin
          ifid_load = 1'b1;
          pc_nxt    = pc_plus4;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  reg_if_id #(
    .NOP_INSTR(NOP_INSTR)
  ) u_reg_if_id (
    .clk             (clk),
    .reset           (reset),
    .load            (ifid_load),
    .flush           (ifid_flush),
    .fetched_instr   (imem_data),
    .fetched_pc_plus4(pc_plus4),
    .instr           (instr_id),
    .pc_plus4        (pc_plus4_id),
    .valid           (valid_id)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_q <= 32'h0;
      stall_q <= 32'h0;
    end else begin
      if (taken_evt) taken_q <= taken_q + 32'd1;
      if (stall_evt) stall_q <= stall_q + 32'd1;
    end
  end

  assign cnt_taken = taken_q;
  assign cnt_stall = stall_q;
`else
  logic unused_evt;
  assign unused_evt = taken_evt ^ stall_evt;
  assign cnt_taken  = 32'h0;
  assign cnt_stall  = 32'h0;
`endif

  // Target byte-offset bits never reach the PC.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

endmodule
